dealer_turn_sequencer: RTL and testbench

Executes the dealer's turn on the command side of the `blackjack::gameCommand` interface. It owns the dealer hand: deals the two opening cards, then repeatedly raises `turnIndicator`, samples the returned `command`, and fetches a card from the deck on HIT. It finishes on STAND, bust or a full hand. It sits between the game top-level FSM, which starts it and reads the result, the deck/shuffler, which supplies cards, and the dealer decision logic, which consumes `turnIndicator`/`handValue` and produces `command`.

---
 rtl/dealer_turn_sequencer_pkg.sv | 36 +++
 rtl/dealer_turn_sequencer_if.sv | 46 ++++
 rtl/dealer_turn_sequencer_card_points.sv | 35 +++
 rtl/dealer_turn_sequencer.sv | 132 +++++++++++++
 tb/tb_dealer_turn_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dealer_turn_sequencer_pkg.sv
// Shared blackjack types: decider command, card rank, dealer FSM states
// and the hand-value constants used by the dealer turn sequencer.
package blackjack;

    typedef enum logic [1:0] {
        HIT   = 2'd0,
        STAND = 2'd1,
        NONE  = 2'd2
    } gameCommand;

    typedef logic [3:0] cardRank;

    localparam logic [4:0] BLACKJACK_LIMIT = 5'd21;
    localparam logic [4:0] ACE_BONUS       = 5'd10;
    localparam logic [4:0] SOFT_MAX        = BLACKJACK_LIMIT - ACE_BONUS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEAL,
        S_EVAL,
        S_ASK,
        S_DONE
    } dealerState;

    // One ace may count 11 whenever that keeps the hand at or under 21.
    function automatic logic [4:0] best_value(
        input logic [4:0] hard,
        input logic       ace
    );
        if (ace && (hard <= SOFT_MAX)) begin
            return hard + ACE_BONUS;
        end
        return hard;
    endfunction

endpackage

// File: rtl/dealer_turn_sequencer_if.sv
// Dealer turn bus: game-FSM start/result, deck card handshake and the
// decision-logic turnIndicator/command/handValue exchange.
interface dealer_turn_sequencer_if;
    import blackjack::*;

    logic       start;
    logic       turnIndicator;
    gameCommand command;
    logic [4:0] handValue;
    logic       card_req;
    logic       card_valid;
    cardRank    card_rank;
    logic [3:0] card_count;
    logic       done;
    logic       bust;
    logic       stood;

    modport master (
        input  start,
        input  command,
        input  card_valid,
        input  card_rank,
        output turnIndicator,
        output handValue,
        output card_req,
        output card_count,
        output done,
        output bust,
        output stood
    );

    modport slave (
        output start,
        output command,
        output card_valid,
        output card_rank,
        input  turnIndicator,
        input  handValue,
        input  card_req,
        input  card_count,
        input  done,
        input  bust,
        input  stood
    );

endinterface

// File: rtl/dealer_turn_sequencer_card_points.sv
// Card rank to blackjack points; ace counts 1 here, the soft bonus is
// applied later from the ace flag.
module card_points
    import blackjack::*;
(
    input  cardRank    rank,
    output logic [3:0] points,
    output logic       is_ace,
    output logic       rank_ok
);

    always_comb begin
        points  = 4'd0;
        is_ace  = 1'b0;
        rank_ok = 1'b0;
        unique case (1'b1)
            (rank == 4'd1): begin
                points  = 4'd1;
                is_ace  = 1'b1;
                rank_ok = 1'b1;
            end
            (rank >= 4'd2 && rank <= 4'd10): begin
                points  = rank;
                rank_ok = 1'b1;
            end
            (rank >= 4'd11 && rank <= 4'd13): begin
                points  = 4'd10;
                rank_ok = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/dealer_turn_sequencer.sv
// Dealer turn FSM: deals two cards, then asks the decider and hits until
// it stands, busts or the hand is full. All outputs are registered.
module dealer_turn_sequencer
    import blackjack::*;
#(
    parameter int MAX_CARDS = 11
) (
    input  logic clk,
    input  logic reset,
    dealer_turn_sequencer_if.master bus
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_CARDS);

    dealerState state_q, state_d;
    logic [4:0] hard_sum_q, hard_sum_d;
    logic       ace_seen_q, ace_seen_d;
    logic [3:0] card_count_q, card_count_d;
    logic [4:0] hand_value_q, hand_value_d;
    logic       bust_q, bust_d;
    logic       stood_q, stood_d;
    logic       done_q, done_d;
    logic       turn_q, turn_d;
    logic       card_req_q, card_req_d;

    logic [3:0] points;
    logic       is_ace;
    logic       rank_ok;
    logic       accept;

    card_points u_points (
        .rank    (bus.card_rank),
        .points  (points),
        .is_ace  (is_ace),
        .rank_ok (rank_ok)
    );

    // Bad ranks never accept, so the request simply stays up.
    assign accept = card_req_q & bus.card_valid & rank_ok;

    always_comb begin
        state_d      = state_q;
        hard_sum_d   = hard_sum_q;
        ace_seen_d   = ace_seen_q;
        card_count_d = card_count_q;
        bust_d       = bust_q;
        stood_d      = stood_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    hard_sum_d   = 5'd0;
                    ace_seen_d   = 1'b0;
                    card_count_d = 4'd0;
                    bust_d       = 1'b0;
                    stood_d      = 1'b0;
                    state_d      = S_DEAL;
                end
            end
            S_DEAL: begin
                if (accept) begin
                    hard_sum_d   = hard_sum_q + {1'b0, points};
                    ace_seen_d   = ace_seen_q | is_ace;
                    card_count_d = card_count_q + 4'd1;
                    state_d      = (card_count_d < 4'd2) ? S_DEAL : S_EVAL;
                end
            end
            S_EVAL: begin
                if (hard_sum_q > BLACKJACK_LIMIT) begin
                    bust_d  = 1'b1;
                    state_d = S_DONE;
                end else if (card_count_q == MAX_CNT) begin
                    stood_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ASK;
                end
            end
            S_ASK: begin
                unique case (bus.command)
                    HIT:   state_d = S_DEAL;
                    STAND: begin
                        stood_d = 1'b1;
                        state_d = S_DONE;
                    end
                    default: begin
                    end
                endcase
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        hand_value_d = best_value(hard_sum_d, ace_seen_d);
        card_req_d   = (state_d == S_DEAL);
        turn_d       = (state_d == S_ASK);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hard_sum_q   <= 5'd0;
            ace_seen_q   <= 1'b0;
            card_count_q <= 4'd0;
            hand_value_q <= 5'd0;
            bust_q       <= 1'b0;
            stood_q      <= 1'b0;
            done_q       <= 1'b0;
            turn_q       <= 1'b0;
            card_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hard_sum_q   <= hard_sum_d;
            ace_seen_q   <= ace_seen_d;
            card_count_q <= card_count_d;
            hand_value_q <= hand_value_d;
            bust_q       <= bust_d;
            stood_q      <= stood_d;
            done_q       <= done_d;
            turn_q       <= turn_d;
            card_req_q   <= card_req_d;
        end
    end

    assign bus.turnIndicator = turn_q;
    assign bus.handValue     = hand_value_q;
    assign bus.card_req      = card_req_q;
    assign bus.card_count    = card_count_q;
    assign bus.done          = done_q;
    assign bus.bust          = bust_q;
    assign bus.stood         = stood_q;

endmodule

// File: tb/tb_dealer_turn_sequencer.sv
// Bench for dealer_turn_sequencer: directed and random dealer turns
// against a card-list hand model, on a default and a 4-card instance.
module tb_dealer_turn_sequencer;
    import blackjack::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       sel;
    logic       card_valid;
    logic [3:0] card_rank;
    gameCommand command;

    always #5 clk = ~clk;

    dealer_turn_sequencer_if ifa ();
    dealer_turn_sequencer_if ifb ();

    assign ifa.start      = start & ~sel;
    assign ifb.start      = start & sel;
    assign ifa.command    = command;
    assign ifb.command    = command;
    assign ifa.card_valid = card_valid & ~sel;
    assign ifb.card_valid = card_valid & sel;
    assign ifa.card_rank  = card_rank;
    assign ifb.card_rank  = card_rank;

    dealer_turn_sequencer #(.MAX_CARDS(11)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    dealer_turn_sequencer #(.MAX_CARDS(4)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    logic       o_turn, o_req, o_done, o_bust, o_stood;
    logic [4:0] o_hv;
    logic [3:0] o_cnt;

    assign o_turn  = sel ? ifb.turnIndicator : ifa.turnIndicator;
    assign o_req   = sel ? ifb.card_req      : ifa.card_req;
    assign o_done  = sel ? ifb.done          : ifa.done;
    assign o_bust  = sel ? ifb.bust          : ifa.bust;
    assign o_stood = sel ? ifb.stood         : ifa.stood;
    assign o_hv    = sel ? ifb.handValue     : ifa.handValue;
    assign o_cnt   = sel ? ifb.card_count    : ifa.card_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Hand model: the list of accepted cards summarised by plain sums.
    int m_hard;
    int m_n;
    bit m_ace;
    int plan[$];

    function automatic int pts(input int r);
        if (r == 1)  return 1;
        if (r <= 10) return r;
        return 10;
    endfunction

    function automatic int best();
        if (m_ace && m_hard + 10 <= 21) return m_hard + 10;
        return m_hard;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic get_card(input int minw, input int maxw,
                            input int badmode);
        int w;
        int r;
        int bads[3];
        bads = '{0, 14, 15};
        w = $urandom_range(minw, maxw);
        card_valid = 1'b0;
        repeat (w) begin
            chk("req_wait", o_req, 1);
            tick();
        end
        if (badmode == 2 || (badmode == 1 && $urandom_range(0, 1) == 1)) begin
            card_valid = 1'b1;
            card_rank  = 4'(bads[$urandom_range(0, 2)]);
            chk("req_bad", o_req, 1);
            tick();
            chk("cnt_bad", o_cnt, m_n);
            chk("req_after_bad", o_req, 1);
        end
        r = (plan.size() > 0) ? plan.pop_front() : int'($urandom_range(1, 13));
        card_valid = 1'b1;
        card_rank  = 4'(r);
        chk("req_card", o_req, 1);
        tick();
        card_valid = 1'b0;
        m_hard += pts(r);
        m_ace  |= (r == 1);
        m_n++;
    endtask

    task automatic turn(input bit s, input int maxc, input int thr,
                        input int minw, input int maxw, input int badmode,
                        input bit pokes, output int done_at);
        int c0;
        int k;
        bit exp_bust;
        sel     = s;
        m_hard  = 0;
        m_n     = 0;
        m_ace   = 1'b0;
        command = NONE;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        c0      = cyc;
        get_card(minw, maxw, badmode);
        get_card(minw, maxw, badmode);
        for (int it = 0; it < 16; it++) begin
            chk("eval_turn", o_turn, 0);
            chk("eval_req", o_req, 0);
            tick();
            if (m_hard > 21 || m_n == maxc) break;
            chk("ask_turn", o_turn, 1);
            chk("ask_hv", o_hv, best());
            chk("ask_cnt", o_cnt, m_n);
            if (pokes) begin
                k = $urandom_range(1, 5);
                card_valid = 1'b1;
                card_rank  = 4'd5;
                start      = 1'b1;
                for (int j = 0; j < k; j++) begin
                    tick();
                    start = 1'b0;
                    chk("hold_turn", o_turn, 1);
                    chk("hold_hv", o_hv, best());
                    chk("hold_cnt", o_cnt, m_n);
                end
                card_valid = 1'b0;
            end
            if (best() < thr) begin
                command = HIT;
                tick();
                command = NONE;
                get_card(minw, maxw, badmode);
            end else begin
                command = STAND;
                tick();
                command = NONE;
                break;
            end
        end
        exp_bust = (m_hard > 21);
        done_at  = cyc - c0 + 1;
        chk("done_pulse", o_done, 1);
        chk("done_turn", o_turn, 0);
        chk("done_bust", o_bust, exp_bust);
        chk("done_stood", o_stood, !exp_bust);
        chk("done_hv", o_hv, best());
        chk("done_cnt", o_cnt, m_n);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_done", o_done, 0);
        chk("idle_req", o_req, 0);
        chk("idle_turn", o_turn, 0);
        chk("idle_bust", o_bust, exp_bust);
        chk("idle_stood", o_stood, !exp_bust);
        chk("idle_hv", o_hv, best());
        chk("idle_cnt", o_cnt, m_n);
        tick();
        chk("idle2_req", o_req, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_turn"}, o_turn, 0);
        chk({tag, "_req"}, o_req, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_bust"}, o_bust, 0);
        chk({tag, "_stood"}, o_stood, 0);
        chk({tag, "_hv"}, o_hv, 0);
        chk({tag, "_cnt"}, o_cnt, 0);
    endtask

    initial begin
        int da;
        bit rs;
        reset      = 1'b1;
        start      = 1'b0;
        sel        = 1'b0;
        card_valid = 1'b0;
        card_rank  = 4'd0;
        command    = NONE;
        tick();
        tick();
        chk_zero("rst_a");
        sel = 1'b1;
        #1;
        chk_zero("rst_b");
        sel   = 1'b0;
        reset = 1'b0;
        tick();

        plan = '{10, 7};
        turn(1'b0, 11, 17, 0, 0, 0, 1'b0, da);
        chk("stand_latency", da, 5);
        chk("stand_hv", o_hv, 17);

        plan = '{1, 6};
        turn(1'b0, 11, 17, 0, 0, 0, 1'b0, da);
        chk("soft17_hv", o_hv, 17);

        plan = '{1, 5, 10, 2};
        turn(1'b0, 11, 17, 0, 0, 0, 1'b0, da);
        chk("hard_hv", o_hv, 18);

        plan = '{10, 6, 9};
        turn(1'b0, 11, 17, 0, 0, 0, 1'b0, da);
        chk("bust_flag", o_bust, 1);
        chk("bust_hv", o_hv, 25);

        plan = '{9, 8};
        turn(1'b0, 11, 17, 3, 3, 2, 1'b1, da);
        chk("bp_cnt", o_cnt, 2);

        plan = '{1, 1, 1, 1};
        turn(1'b1, 4, 99, 0, 0, 0, 1'b1, da);
        chk("max_stood", o_stood, 1);
        chk("max_hv", o_hv, 14);
        chk("max_cnt", o_cnt, 4);

        sel        = 1'b0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        card_valid = 1'b1;
        card_rank  = 4'd7;
        tick();
        chk("pre_rst_req", o_req, 1);
        chk("pre_rst_cnt", o_cnt, 1);
        card_valid = 1'b0;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
        chk_zero("mid_rst");
        tick();
        chk("post_rst_req", o_req, 0);

        for (int i = 0; i < 30; i++) begin
            plan.delete();
            rs = 1'($urandom_range(0, 1));
            turn(rs, rs ? 4 : 11, $urandom_range(12, 20), 0,
                 $urandom_range(0, 3), 1, 1'($urandom_range(0, 1)), da);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
